// File: rtl/ticket_dispense_ctrl.sv
// Ticket dispense controller: presents tickets one at a time until taken, with
// inter-ticket gap, presentation timeout, bounded retries and a latched fault.
module ticket_dispense_ctrl #(
    parameter int CNT_W     = 4,
    parameter int TIMEOUT   = 16,
    parameter int GAP_CYC   = 2,
    parameter int MAX_RETRY = 2,
    parameter int TMR_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_RDY,
    input  logic [CNT_W-1:0] qty,
    input  logic             sensor_t,
    input  logic             fault_clr,
    output logic             ticket_out,
    output logic             state_cmp,
    output logic             busy,
    output logic             fault,
    output logic [CNT_W-1:0] dispensed
);

    localparam int RTY_W = $clog2(MAX_RETRY + 1);
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] GAP_LAST = TMR_W'(GAP_CYC - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_RETRY,
        S_GAP,
        S_DONE,
        S_FAULT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] qty_reg, qty_next;
    logic [CNT_W-1:0] dispensed_reg, dispensed_next;
    logic [RTY_W-1:0] retry_reg, retry_next;
    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic             sensor_q;
    logic             take;

    // Rising edge only, so a sensor held high across the gap counts once.
    assign take = sensor_t & ~sensor_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            qty_reg       <= '0;
            dispensed_reg <= '0;
            retry_reg     <= '0;
            tmr_reg       <= '0;
            sensor_q      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            qty_reg       <= qty_next;
            dispensed_reg <= dispensed_next;
            retry_reg     <= retry_next;
            tmr_reg       <= tmr_next;
            sensor_q      <= sensor_t;
        end
    end

    always_comb begin
        state_next     = state_reg;
        qty_next       = qty_reg;
        dispensed_next = dispensed_reg;
        retry_next     = retry_reg;
        tmr_next       = tmr_reg;
        case (state_reg)
            S_IDLE: begin
                if (in_RDY) begin
                    qty_next       = qty;
                    dispensed_next = '0;
                    retry_next     = '0;
                    tmr_next       = '0;
                    state_next     = (qty == '0) ? S_DONE : S_FEED;
                end
            end
            S_FEED: begin
                // A take on the timeout cycle still counts the ticket.
                if (take) begin
                    dispensed_next = dispensed_reg + CNT_W'(1);
                    retry_next     = '0;
                    tmr_next       = '0;
                    state_next     = (dispensed_next == qty_reg) ? S_DONE : S_GAP;
                end else if (tmr_reg == TMO_LAST) begin
                    retry_next = retry_reg + RTY_W'(1);
                    tmr_next   = '0;
                    state_next = (retry_next == RTY_MAX) ? S_FAULT : S_RETRY;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            S_RETRY: begin
                tmr_next   = '0;
                state_next = S_FEED;
            end
            S_GAP: begin
                if (tmr_reg == GAP_LAST) begin
                    tmr_next   = '0;
                    state_next = S_FEED;
                end else begin
                    tmr_next = tmr_reg + TMR_W'(1);
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clr) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign ticket_out = (state_reg == S_FEED);
    assign state_cmp  = (state_reg == S_DONE);
    assign busy       = (state_reg != S_IDLE);
    assign fault      = (state_reg == S_FAULT);
    assign dispensed  = dispensed_reg;

endmodule

// File: tb/tb_ticket_dispense_ctrl.sv
// Testbench for ticket_dispense_ctrl: directed scenarios plus randomized traffic
// checked each cycle against a countdown-based behavioural model.
module tb_ticket_dispense_ctrl;

    localparam int CNT_W     = 4;
    localparam int TIMEOUT   = 8;
    localparam int GAP_CYC   = 2;
    localparam int MAX_RETRY = 2;
    localparam int TMR_W     = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_rdy = 1'b0;
    logic [CNT_W-1:0] qty = '0;
    logic             sensor_t = 1'b0;
    logic             fault_clr = 1'b0;
    logic             ticket_out;
    logic             state_cmp;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] dispensed;

    int total_cnt = 0;
    int bad_cnt   = 0;

    ticket_dispense_ctrl #(
        .CNT_W    (CNT_W),
        .TIMEOUT  (TIMEOUT),
        .GAP_CYC  (GAP_CYC),
        .MAX_RETRY(MAX_RETRY),
        .TMR_W    (TMR_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_RDY    (in_rdy),
        .qty       (qty),
        .sensor_t  (sensor_t),
        .fault_clr (fault_clr),
        .ticket_out(ticket_out),
        .state_cmp (state_cmp),
        .busy      (busy),
        .fault     (fault),
        .dispensed (dispensed)
    );

    always #5 clk = ~clk;

    // Model: "presenting" with an age, or a low-time countdown covering both
    // the retry pause and the inter-ticket gap.
    bit m_busy, m_ticket, m_cmp, m_fault, m_prev;
    int m_disp, m_qty, m_fails, m_age, m_low;

    task automatic check_val(input string tag, input int got, input int exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_ticket = 0; m_cmp = 0; m_fault = 0; m_prev = 0;
        m_disp = 0; m_qty = 0; m_fails = 0; m_age = 0; m_low = 0;
    endtask

    task automatic model_step();
        bit take;
        take = sensor_t && !m_prev;
        if (m_fault) begin
            if (fault_clr) begin
                m_fault = 0;
                m_busy  = 0;
                $display("fault cleared, dispensed=%0d", m_disp);
            end
        end else if (m_cmp) begin
            m_cmp  = 0;
            m_busy = 0;
        end else if (!m_busy) begin
            if (in_rdy) begin
                m_qty = int'(qty); m_disp = 0; m_fails = 0; m_busy = 1;
                if (m_qty == 0) m_cmp = 1;
                else begin
                    m_ticket = 1;
                    m_age    = 0;
                end
            end
        end else if (m_ticket) begin
            if (take) begin
                m_disp++;
                m_fails  = 0;
                m_ticket = 0;
                if (m_disp == m_qty) begin
                    m_cmp = 1;
                    $display("batch done qty=%0d dispensed=%0d", m_qty, m_disp);
                end else m_low = GAP_CYC;
            end else if (m_age == TIMEOUT - 1) begin
                m_fails++;
                m_ticket = 0;
                if (m_fails == MAX_RETRY) begin
                    m_fault = 1;
                    $display("fault entered, dispensed=%0d of %0d", m_disp, m_qty);
                end else m_low = 1;
            end else m_age++;
        end else begin
            m_low--;
            if (m_low == 0) begin
                m_ticket = 1;
                m_age    = 0;
            end
        end
        m_prev = sensor_t;
    endtask

    task automatic compare_all();
        check_val("ticket_out", int'(ticket_out), int'(m_ticket));
        check_val("state_cmp",  int'(state_cmp),  int'(m_cmp));
        check_val("busy",       int'(busy),       int'(m_busy));
        check_val("fault",      int'(fault),      int'(m_fault));
        check_val("dispensed",  int'(dispensed),  m_disp);
    endtask

    task automatic cycle(input bit rdy, input int q, input bit s, input bit clr);
        in_rdy    = rdy;
        qty       = CNT_W'(q);
        sensor_t  = s;
        fault_clr = clr;
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic idle_cycles(input int n, input bit s);
        for (int i = 0; i < n; i++) cycle(0, 0, s, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;

        // Single ticket, taken 3 cycles into presentation.
        cycle(1, 1, 0, 0);
        idle_cycles(3, 0);
        cycle(0, 0, 1, 0);
        check_val("single_cmp", int'(state_cmp), 1);
        check_val("single_disp", int'(dispensed), 1);
        idle_cycles(2, 0);

        // Batch of 3 with sensor held high through the gaps.
        cycle(1, 3, 0, 0);
        for (int t = 0; t < 3; t++) begin
            idle_cycles(1, 0);
            idle_cycles(GAP_CYC + 2, 1);
        end
        check_val("batch_disp", int'(dispensed), 3);
        idle_cycles(3, 0);

        // Retry then success on the second attempt.
        cycle(1, 1, 0, 0);
        idle_cycles(TIMEOUT + 1 + 1, 0);
        cycle(0, 0, 1, 0);
        check_val("retry_cmp", int'(state_cmp), 1);
        idle_cycles(2, 0);

        // Fault: first ticket taken, second never taken; in_RDY ignored in fault.
        cycle(1, 2, 0, 0);
        cycle(0, 0, 1, 0);
        idle_cycles(GAP_CYC + 2 * TIMEOUT + 3, 0);
        check_val("fault_set", int'(fault), 1);
        check_val("fault_disp", int'(dispensed), 1);
        cycle(1, 4, 0, 0);
        cycle(0, 0, 0, 1);
        check_val("fault_clr_busy", int'(busy), 0);
        idle_cycles(1, 0);

        // qty=0, take on the timeout cycle, second in_RDY during FEED.
        cycle(1, 0, 0, 0);
        check_val("qty0_cmp", int'(state_cmp), 1);
        idle_cycles(1, 0);
        cycle(1, 1, 0, 0);
        cycle(1, 7, 0, 0);
        idle_cycles(TIMEOUT - 2, 0);
        cycle(0, 0, 1, 0);
        check_val("tmo_take_cmp", int'(state_cmp), 1);
        check_val("tmo_take_disp", int'(dispensed), 1);
        idle_cycles(2, 0);

        // Asynchronous reset mid-batch (qty=5, two taken).
        cycle(1, 5, 0, 0);
        for (int t = 0; t < 2; t++) begin
            cycle(0, 0, 1, 0);
            idle_cycles(GAP_CYC + 1, 0);
        end
        check_val("pre_rst_disp", int'(dispensed), 2);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1;
        compare_all();
        rst = 1'b0;
        cycle(1, 2, 0, 0);
        for (int t = 0; t < 2; t++) begin
            cycle(0, 0, 1, 0);
            idle_cycles(GAP_CYC + 1, 0);
        end

        // Randomized traffic with a take-rate that changes every 40 cycles.
        for (int seg = 0; seg < 100; seg++) begin
            int rate;
            case ($urandom_range(0, 3))
                0:       rate = 0;
                1:       rate = 8;
                default: rate = 35;
            endcase
            for (int i = 0; i < 40; i++) begin
                cycle($urandom_range(0, 3) == 0, int'($urandom_range(0, 5)),
                      $urandom_range(0, 99) < rate, $urandom_range(0, 7) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/ticket_dispense_ctrl.md
# ticket_dispense_ctrl

Parametrised ticket dispense controller for the vending machine output stage. On a ready pulse from the upstream payment/selection stage it dispenses a requested number of tickets one at a time, presenting each until the take sensor confirms removal. Adds multi-ticket batches, an inter-ticket gap, a presentation timeout with bounded retries, and a latched fault. Signals batch completion to the next stage with a one-cycle `state_cmp` pulse.

## Interface
- `CNT_W`, 4: width of the ticket quantity and dispensed count.
- `TIMEOUT`, 16: cycles a ticket is presented before the attempt is declared failed (≥2).
- `GAP_CYC`, 2: idle cycles between consecutive tickets (≥1).
- `MAX_RETRY`, 2: failed attempts allowed per ticket before fault (≥1).
- `TMR_W`, 8: width of internal timers; must hold max(TIMEOUT, GAP_CYC).

- `clk` input 1: single system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_RDY` input 1: start request from upstream, sampled only in IDLE.
- `qty` input CNT_W: tickets to dispense, captured with `in_RDY`.
- `sensor_t` input 1: ticket-taken sensor, level, synchronous to `clk`.
- `fault_clr` input 1: clears FAULT, returns to IDLE.
- `ticket_out` output 1: ticket presented / feed motor on.
- `state_cmp` output 1: one-cycle batch-complete pulse.
- `busy` output 1: high in any state other than IDLE.
- `fault` output 1: high in FAULT.
- `dispensed` output CNT_W: tickets confirmed taken in the current/last batch.

## Operation
- States: IDLE, FEED, RETRY, GAP, DONE, FAULT. All outputs are registered or decoded from registered state.
- `sensor_t` is registered into `sensor_q`; `take = sensor_t & ~sensor_q` (rising edge). A level held high counts once.
- IDLE: on `in_RDY`=1, capture `qty` into `qty_r`, clear `dispensed` and the retry counter. If `qty`=0, go to DONE; otherwise go to FEED with the timer cleared. `in_RDY` is ignored in all other states.
- FEED: `ticket_out`=1; the timer increments every cycle.
  - On `take`: `dispensed`+1 and the retry counter is cleared. If the new count equals `qty_r`, go to DONE; otherwise go to GAP.
  - If there is no `take` and the timer reaches TIMEOUT-1: the retry counter increments. If the new value equals MAX_RETRY, go to FAULT; otherwise go to RETRY.
  - If `take` and timeout occur in the same cycle, `take` wins.
- RETRY: `ticket_out`=0 for exactly 1 cycle, then FEED with the timer cleared. `take` is ignored.
- GAP: `ticket_out`=0 for GAP_CYC cycles, then FEED with the timer cleared. `take` is ignored.
- DONE: `state_cmp`=1 for 1 cycle, then IDLE. `dispensed` holds its value until the next accepted `in_RDY`.
- FAULT: `fault`=1 and `ticket_out`=0. Stays in FAULT until `fault_clr`=1, then goes to IDLE. `dispensed` holds the partial count.
- `fault_clr` has no effect outside FAULT.
- Reset (any time, including mid-batch): go to IDLE. `ticket_out`, `state_cmp`, `busy` and `fault` are 0; `dispensed`, `qty_r`, the timers, the retry counter and `sensor_q` are 0. The batch in progress is abandoned.

## Timing
- Latency from `in_RDY` to `ticket_out`: `in_RDY` sampled at edge k, `ticket_out`=1 after edge k (one state register delay).
- Sensor to deassert: `sensor_t` first high at edge m (with `sensor_q`=0), `ticket_out` falls and `dispensed` updates after edge m.
- Gap between tickets: `ticket_out` low for exactly GAP_CYC cycles.
- Timeout: with no `take`, `ticket_out` stays high for exactly TIMEOUT cycles per attempt.
- Last ticket: `take` at edge m puts DONE after m, so `state_cmp` is high for one cycle after edge m.
- `qty`=0: `state_cmp` goes high one cycle after `in_RDY` is sampled; `ticket_out` never asserts.
- Earliest next request: `busy` falls with the DONE→IDLE transition, and a new `in_RDY` is accepted the cycle after.
- Arithmetic: `dispensed` never exceeds `qty_r`; there is no wrap in a valid batch. Counter compares are on the full width.

## Test plan
Unless noted, use TIMEOUT=8, GAP_CYC=2, MAX_RETRY=2, CNT_W=4.
- **Single ticket:** reset, `qty`=1, pulse `in_RDY`, raise `sensor_t` 3 cycles later. Expect `ticket_out` high for 4 cycles, `dispensed`=1, one `state_cmp` pulse, `busy` low afterwards.
- **Batch of 3:** `qty`=3, take each ticket 2 cycles after presentation. Expect 3 `ticket_out` pulses separated by exactly 2 low cycles, `dispensed` stepping 1→2→3, one `state_cmp` only after the 3rd, and `sensor_t` held high through the gap not double-counted.
- **Retry then success:** `qty`=1, no take on the first attempt. Expect `ticket_out` high for 8 cycles, low for 1, then high again. Take at cycle 2 of the second attempt: expect `state_cmp`, `fault`=0.
- **Fault:** `qty`=2, the first ticket is taken, then never take the second. Expect two 8-cycle attempts, then `fault`=1, `dispensed`=1 held, `in_RDY` ignored. Pulse `fault_clr`: expect IDLE, `fault`=0.
- **Edge cases:** `qty`=0 gives `state_cmp` one cycle after `in_RDY` with no `ticket_out`. `take` on the timeout cycle counts the ticket and no retry occurs. A second `in_RDY` during FEED is ignored.
- **Reset mid-batch:** assert `rst` asynchronously mid-batch with `qty`=5 and `dispensed`=2. Expect all outputs 0 immediately and a fresh batch to run normally after release.
